// File: rtl/falu_pipe_pkg.sv
// falu_pipe_pkg: shared widths, encodings and the combinational FP core used by
// falu_pipe.
//   XLEN / ROB_INDEX_WIDTH / PHY_REG_ADDR_WIDTH : default datapath and tag widths
//   RM_DYN       : instruction rm value that selects the dynamic fcsr.frm
//   FFLAG_*      : bit positions inside the 5-bit fflags vector (NV,DZ,OF,UF,NX)
//   falu_fmt_e   : operand format (S = single, D = double)
//   falu_op_e    : function-select encodings handled by the core
//   fonecycle()  : single-cycle FP core (add/sub, sign injection)
package falu_pipe_pkg;

    localparam int XLEN               = 64;
    localparam int ROB_INDEX_WIDTH    = 6;
    localparam int PHY_REG_ADDR_WIDTH = 6;

    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    typedef enum logic [1:0] {
        FMT_S = 2'b00,
        FMT_D = 2'b01
    } falu_fmt_e;

    typedef enum logic [4:0] {
        OP_FADD   = 5'd0,
        OP_FSUB   = 5'd1,
        OP_FSGNJ  = 5'd2,
        OP_FSGNJN = 5'd3,
        OP_FSGNJX = 5'd4
    } falu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      fflags;
    } core_res_t;

    // rm values 101/110/111 are reserved once the dynamic mode is resolved.
    function automatic logic rm_illegal(input logic [2:0] rm);
        return rm inside {3'b101, 3'b110, 3'b111};
    endfunction

    // Single-cycle core. Add/sub works on a common 57-bit mantissa layout
    // (carry bit 56, hidden bit 55, fraction below) and truncates the result;
    // discarded bits raise NX. NaN/Inf operands are not special-cased.
    function automatic core_res_t fonecycle(input logic [4:0]      op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b,
                                            input logic [1:0]      fmt);
        core_res_t   r;
        logic        is_s, sa, sb, sticky, tmp_s;
        int unsigned ea, eb, er, d, emax, tmp_e;
        logic [56:0] ma, mb, sum, tmp_m;

        r      = '0;
        sticky = 1'b0;
        tmp_s  = 1'b0;
        d      = 0;
        er     = 0;
        sum    = '0;
        is_s   = (fmt == FMT_S);
        sa     = is_s ? a[31] : a[63];
        sb     = is_s ? b[31] : b[63];
        if (is_s) begin
            ea   = 32'(a[30:23]);
            eb   = 32'(b[30:23]);
            ma   = {1'b0, |a[30:23], a[22:0], 32'b0};
            mb   = {1'b0, |b[30:23], b[22:0], 32'b0};
            emax = 255;
        end else begin
            ea   = 32'(a[62:52]);
            eb   = 32'(b[62:52]);
            ma   = {1'b0, |a[62:52], a[51:0], 3'b0};
            mb   = {1'b0, |b[62:52], b[51:0], 3'b0};
            emax = 2047;
        end
        // Subnormals share the minimum exponent, with a clear hidden bit.
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;

        case (op)
            OP_FADD, OP_FSUB: begin
                if (op == OP_FSUB) sb = ~sb;
                if (eb > ea || (eb == ea && mb > ma)) begin
                    tmp_s = sa; sa = sb; sb = tmp_s;
                    tmp_e = ea; ea = eb; eb = tmp_e;
                    tmp_m = ma; ma = mb; mb = tmp_m;
                end
                d = ea - eb;
                if (d > 56) begin
                    sticky = |mb;
                    mb     = '0;
                end else begin
                    sticky = |(mb & ((57'd1 << d) - 57'd1));
                    mb     = mb >> d;
                end
                sum = (sa == sb) ? ma + mb : ma - mb;
                // Bits shifted out of the subtrahend make the exact difference
                // slightly smaller; one unit off the bottom keeps truncation exact.
                if (sa != sb && sticky) sum = sum - 57'd1;
                er = ea;
                if (sum != '0) begin
                    if (sum[56]) begin
                        sticky = sticky | sum[0];
                        sum    = sum >> 1;
                        er     = er + 1;
                    end
                    for (int unsigned i = 0; i < 56; i++) begin
                        if (!sum[55] && er > 1) begin
                            sum = sum << 1;
                            er  = er - 1;
                        end
                    end
                    if (!sum[55]) er = 0;
                    if (is_s) begin
                        r.fflags[FFLAG_NX] = sticky | (|sum[31:0]);
                        r.result           = {32'b0, sa, er[7:0], sum[54:32]};
                    end else begin
                        r.fflags[FFLAG_NX] = sticky | (|sum[2:0]);
                        r.result           = {sa, er[10:0], sum[54:3]};
                    end
                    if (er == 0 && r.fflags[FFLAG_NX]) r.fflags[FFLAG_UF] = 1'b1;
                    if (er >= emax) begin
                        r.fflags[FFLAG_OF] = 1'b1;
                        r.fflags[FFLAG_NX] = 1'b1;
                        r.result = is_s ? {32'b0, sa, 8'hFF, 23'b0} : {sa, 11'h7FF, 52'b0};
                    end
                end
            end
            OP_FSGNJ, OP_FSGNJN, OP_FSGNJX: begin
                tmp_s    = (op == OP_FSGNJ) ? sb : (op == OP_FSGNJN) ? ~sb : (sa ^ sb);
                r.result = a;
                if (is_s) r.result[31] = tmp_s;
                else      r.result[63] = tmp_s;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/falu_pipe_stage.sv
// falu_pipe_stage: one pipeline register with a valid bit.
//   clk, rstn  : clock, async active-low reset (clears valid and payload)
//   flush      : clears valid (highest priority after reset)
//   adv        : stage takes in_valid; payload loads only when in_valid is set
//   clr        : clears valid when not advancing (output drain while held)
//   in_valid/in_data   : upstream valid and payload
//   out_valid/out_data : registered valid and payload
module falu_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         adv,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end else if (clr) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/falu_pipe.sv
// falu_pipe: pipelined FP ALU functional unit (RCU issue -> RCU writeback).
//   Request side : rcu_fu_falu_req_valid_i / fu_rcu_falu_req_ready_o, operands,
//                  function select, rm, fcsr frm, fmt, ROB tag, destination.
//   Response side: fu_rcu_falu_resp_valid_o / rcu_fu_falu_resp_ready_i, result
//                  (NaN-boxed for S), fflags + fflags_valid, illegal_rm, tags.
//   trap flushes every in-flight op; wfi freezes the pipe (output may drain).
//   PIPE_DEPTH (1..4) register stages; stage 0 feeds the core, the last stage
//   is the output register.
module falu_pipe #(
    parameter int XLEN               = falu_pipe_pkg::XLEN,
    parameter int ROB_INDEX_WIDTH    = falu_pipe_pkg::ROB_INDEX_WIDTH,
    parameter int PHY_REG_ADDR_WIDTH = falu_pipe_pkg::PHY_REG_ADDR_WIDTH,
    parameter int PIPE_DEPTH         = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          trap,
    input  logic                          wfi,
    input  logic                          rcu_fu_falu_req_valid_i,
    output logic                          fu_rcu_falu_req_ready_o,
    input  logic [XLEN-1:0]               opr1_i,
    input  logic [XLEN-1:0]               opr2_i,
    input  logic [XLEN-1:0]               opr3_i,
    input  logic [4:0]                    falu_function_select_i,
    input  logic [2:0]                    falu_rounding_mode_i,
    input  logic [2:0]                    fcsr_frm_i,
    input  logic [1:0]                    falu_fmt_i,
    input  logic [ROB_INDEX_WIDTH-1:0]    rob_index_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr_i,
    output logic                          fu_rcu_falu_resp_valid_o,
    input  logic                          rcu_fu_falu_resp_ready_i,
    output logic [XLEN-1:0]               falu_result_o,
    output logic [4:0]                    fu_rcu_falu_fflags_o,
    output logic                          fflags_valid_o,
    output logic                          fu_rcu_falu_illegal_rm_o,
    output logic [ROB_INDEX_WIDTH-1:0]    rob_index_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr_o
);
    import falu_pipe_pkg::*;

    localparam int RAW_W = 2*XLEN + 5 + 2 + 1 + ROB_INDEX_WIDTH + PHY_REG_ADDR_WIDTH;
    localparam int RES_W = XLEN + 5 + 1 + 1 + ROB_INDEX_WIDTH + PHY_REG_ADDR_WIDTH;

    logic [PIPE_DEPTH-1:0]         vld, free, adv;
    logic [RAW_W-1:0]              raw_d, raw_q;
    logic [RES_W-1:0]              core_res;
    logic [RES_W-1:0]              res_q [PIPE_DEPTH];
    logic [2:0]                    rm_res;
    logic                          accept;
    logic                          unused_opr3;

    logic [XLEN-1:0]               c_opr1, c_opr2, c_result;
    logic [4:0]                    c_func;
    logic [1:0]                    c_fmt;
    logic                          c_illegal;
    logic [ROB_INDEX_WIDTH-1:0]    c_rob;
    logic [PHY_REG_ADDR_WIDTH-1:0] c_prd;
    core_res_t                     core_out;

    // The supported op set uses two sources; opr3 is reserved for fused ops.
    assign unused_opr3 = ^opr3_i;

    assign rm_res = (falu_rounding_mode_i == RM_DYN) ? fcsr_frm_i : falu_rounding_mode_i;
    assign raw_d  = {opr1_i, opr2_i, falu_function_select_i, falu_fmt_i,
                     rm_illegal(rm_res), rob_index_i, prd_addr_i};

    // A stage is free if empty or its content moves on this edge. The chain
    // runs back from the output so ready never depends on req_valid.
    always_comb begin
        free = '0;
        free[PIPE_DEPTH-1] = !vld[PIPE_DEPTH-1] | rcu_fu_falu_resp_ready_i;
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
            free[PIPE_DEPTH-1-i] = !vld[PIPE_DEPTH-1-i] | (!wfi & free[PIPE_DEPTH-i]);
        end
        adv = {PIPE_DEPTH{!wfi}} & free;
    end

    assign fu_rcu_falu_req_ready_o = !trap & !wfi & free[0];
    assign accept = rcu_fu_falu_req_valid_i & fu_rcu_falu_req_ready_o;

    always_comb begin
        {c_opr1, c_opr2, c_func, c_fmt, c_illegal, c_rob, c_prd} = raw_q;
        core_out = fonecycle(c_func, c_opr1, c_opr2, c_fmt);
        c_result = (c_fmt == FMT_S) ? {32'hFFFF_FFFF, core_out.result[31:0]} : core_out.result;
        if (c_illegal) core_res = {{XLEN{1'b0}}, 5'b0, 1'b0, 1'b1, c_rob, c_prd};
        else           core_res = {c_result, core_out.fflags, 1'b1, 1'b0, c_rob, c_prd};
    end

    // With a single stage the core sits in front of the only (output) register.
    if (PIPE_DEPTH == 1) begin : g_single
        assign raw_q = raw_d;
        falu_pipe_stage #(.W(RES_W)) u_stage0 (
            .clk(clk), .rstn(rstn), .flush(trap), .adv(adv[0]),
            .clr(rcu_fu_falu_resp_ready_i), .in_valid(accept), .in_data(core_res),
            .out_valid(vld[0]), .out_data(res_q[0])
        );
    end else begin : g_multi
        falu_pipe_stage #(.W(RAW_W)) u_stage0 (
            .clk(clk), .rstn(rstn), .flush(trap), .adv(adv[0]),
            .clr(1'b0), .in_valid(accept), .in_data(raw_d),
            .out_valid(vld[0]), .out_data(raw_q)
        );
        assign res_q[0] = core_res;
        for (genvar k = 1; k < PIPE_DEPTH; k++) begin : g_stage
            falu_pipe_stage #(.W(RES_W)) u_stage (
                .clk(clk), .rstn(rstn), .flush(trap), .adv(adv[k]),
                .clr(rcu_fu_falu_resp_ready_i && (k == PIPE_DEPTH-1)),
                .in_valid(vld[k-1]), .in_data(res_q[k-1]),
                .out_valid(vld[k]), .out_data(res_q[k])
            );
        end
    end

    assign fu_rcu_falu_resp_valid_o = vld[PIPE_DEPTH-1];
    assign {falu_result_o, fu_rcu_falu_fflags_o, fflags_valid_o, fu_rcu_falu_illegal_rm_o,
            rob_index_o, prd_addr_o} = res_q[PIPE_DEPTH-1];

endmodule
